alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 28 ++
 rtl/alu_op_fifo.sv | 74 +++++++
 rtl/alu_issue.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue block: widths, opcodes, queue entry
// layout and FSM state encoding.
package alu_issue_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned ENTRY_W = OP_W + 2 * DATA_W;

    // ALU opcodes; the issue logic forwards them untouched
    localparam logic [OP_W-1:0] OP_ADD  = 2'd0;
    localparam logic [OP_W-1:0] OP_SHL  = 2'd1;
    localparam logic [OP_W-1:0] OP_SHR  = 2'd2;
    localparam logic [OP_W-1:0] OP_NAND = 2'd3;

    // Issue FSM states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXEC    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    // One queued operation, packed as {fs, a, b}
    typedef struct packed {
        logic [OP_W-1:0]   fs;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_t;

endpackage

// File: rtl/alu_op_fifo.sv
// Synchronous FIFO holding pending ALU operations. Full/empty/level come
// straight from the registered occupancy count.
module alu_op_fifo
    import alu_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [ENTRY_W-1:0]             wdata,
    input  logic                           pop,
    output logic [ENTRY_W-1:0]             rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [LVL_W-1:0]   count_q, count_d;
    logic               push_en, pop_en;

    assign full    = (count_q == LVL_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rdata   = mem_q[rptr_q];
    // A refused push stays refused even if a pop frees a slot this edge
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n)
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_en) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        if (push_en && !pop_en) begin
            count_d = count_q + LVL_W'(1);
        end else if (!push_en && pop_en) begin
            count_d = count_q - LVL_W'(1);
        end
    end

    // Pointer/count registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Issues queued operations one at a time to an external registered ALU and
// holds each result until the consumer takes it.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [OP_W-1:0]                in_fs,
    input  logic [DATA_W-1:0]              in_a,
    input  logic [DATA_W-1:0]              in_b,
    output logic [OP_W-1:0]                alu_fs,
    output logic [DATA_W-1:0]              alu_a,
    output logic [DATA_W-1:0]              alu_b,
    input  logic [DATA_W-1:0]              alu_c,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_c,
    output logic [OP_W-1:0]                out_fs,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    logic [1:0]         state_q, state_d;
    logic [OP_W-1:0]    alu_fs_q, alu_fs_d;
    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_c_q, out_c_d;
    logic [OP_W-1:0]    out_fs_q, out_fs_d;

    logic               fifo_full, fifo_empty, fifo_pop;
    logic [ENTRY_W-1:0] fifo_rdata;
    op_t                head;

    assign in_ready = !fifo_full;
    assign head     = op_t'(fifo_rdata);

    alu_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .wdata ({in_fs, in_a, in_b}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Issue FSM: pop -> present operands -> capture ALU result -> hold for consumer
    always_comb begin
        state_d     = state_q;
        alu_fs_d    = alu_fs_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        out_valid_d = out_valid_q;
        out_c_d     = out_c_q;
        out_fs_d    = out_fs_q;
        fifo_pop    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    alu_fs_d = head.fs;
                    alu_a_d  = head.a;
                    alu_b_d  = head.b;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // ALU registers operands on this edge; result visible next cycle
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                out_c_d     = alu_c;
                out_fs_d    = alu_fs_q;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        alu_fs_d = head.fs;
                        alu_a_d  = head.a;
                        alu_b_d  = head.b;
                        state_d  = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset wins over every handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_fs_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_c_q     <= '0;
            out_fs_q    <= '0;
        end else begin
            state_q     <= state_d;
            alu_fs_q    <= alu_fs_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            out_valid_q <= out_valid_d;
            out_c_q     <= out_c_d;
            out_fs_q    <= out_fs_d;
        end
    end

    assign alu_fs    = alu_fs_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign out_valid = out_valid_q;
    assign out_c     = out_c_q;
    assign out_fs    = out_fs_q;

endmodule
